// File: rtl/request_queue_unit.sv
// request_queue_unit: FIFO of up to DEPTH datapath memory requests (load/store).
// Requests are captured on ihit and presented to the dcache in order on dREN/dWEN.
// Each request retires on dhit. Halt drains the queue in order: RUN -> DRAIN -> HALTED.
// Optional feature macro: REQUEST_QUEUE_STATS_EN adds saturating retire/stall counters.
// When the macro is undefined, n_rd/n_wr/n_stall read as 0.
module request_queue_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              halt,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dRead,
  input  logic              dWrite,
  input  logic [ADDR_W-1:0] daddr_in,
  input  logic [DATA_W-1:0] dstore_in,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] dstore,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              halted,
  output logic              err,
  output logic [31:0]       n_rd,
  output logic [31:0]       n_wr,
  output logic [31:0]       n_stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr [DEPTH];
  logic [DATA_W-1:0]   r_data [DEPTH];
  logic [DEPTH-1:0]    r_is_wr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_err;

  logic                w_full;
  logic                w_empty;
  logic                w_run;
  logic                w_push;
  logic                w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_run   = (r_state == S_RUN);
  assign w_pop   = dhit && !w_empty;
  // A pop frees a slot in the same cycle, so a full queue still accepts a push then.
  assign w_push  = ihit && (dRead || dWrite) && w_run && !halt && (!w_full || w_pop);

  assign iREN   = w_run && !halt && !w_full;
  assign full   = w_full;
  assign empty  = w_empty;
  assign count  = r_count;
  assign halted = (r_state == S_HALTED);
  assign err    = r_err;
  // Head outputs are forced to zero while empty so stale slot contents never leak out.
  assign dREN   = !w_empty && !r_is_wr[r_rd_ptr];
  assign dWEN   = !w_empty &&  r_is_wr[r_rd_ptr];
  assign daddr  = w_empty ? '0 : r_addr[r_rd_ptr];
  assign dstore = w_empty ? '0 : r_data[r_rd_ptr];

  // Queue storage: written only on push; contents are meaningless while the slot is free.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_addr[r_wr_ptr]  <= daddr_in;
      r_data[r_wr_ptr]  <= dstore_in;
      r_is_wr[r_wr_ptr] <= dWrite;
    end
  end

  // Pointers, occupancy and sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if ((w_push && dRead && dWrite) || (dhit && w_empty)) r_err <= 1'b1;
    end
  end

  // Control FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state: halt starts the drain; once empty the unit parks until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:    if (halt)    w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_empty) w_state_nxt = S_HALTED;
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_RUN;
    endcase
  end

`ifdef REQUEST_QUEUE_STATS_EN
  logic [31:0] r_n_rd;
  logic [31:0] r_n_wr;
  logic [31:0] r_n_stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Retire and stall statistics, saturating at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_n_rd    <= '0;
      r_n_wr    <= '0;
      r_n_stall <= '0;
    end else begin
      if (w_pop && !r_is_wr[r_rd_ptr])   r_n_rd    <= sat_inc(r_n_rd);
      if (w_pop &&  r_is_wr[r_rd_ptr])   r_n_wr    <= sat_inc(r_n_wr);
      if (ihit && w_full && w_run)       r_n_stall <= sat_inc(r_n_stall);
    end
  end

  assign n_rd    = r_n_rd;
  assign n_wr    = r_n_wr;
  assign n_stall = r_n_stall;
`else
  assign n_rd    = 32'd0;
  assign n_wr    = 32'd0;
  assign n_stall = 32'd0;
`endif

endmodule
